// File: rtl/frac_clken_pkg.sv
// frac_clken_pkg: shared widths, the config record and helper functions for
// the fractional clock-enable generator.
package frac_clken_pkg;

  // Default accumulator / MULT / DIV width.
  localparam int unsigned W_DEFAULT = 16;
  // Largest supported channel count.
  localparam int unsigned NCH_MAX   = 16;
  // The pending-config record is sized for the default width; W must not exceed it.
  localparam int unsigned CFG_W     = W_DEFAULT;

  // Ceiling log2, 0 for n<=1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Channel-select width; never zero so a single-channel build still has a port.
  function automatic int unsigned chan_w(input int unsigned nch);
    return (clog2(nch) == 0) ? 1 : clog2(nch);
  endfunction

  localparam int unsigned CHAN_W = clog2(NCH_MAX);

  // One configuration request as held in the pending slot.
  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [CFG_W-1:0]  mult;
    logic [CFG_W-1:0]  div;
  } cfg_t;

  // A request is usable only with a non-zero DIV, MULT<=DIV and an existing channel.
  function automatic logic cfg_is_valid(input logic [CFG_W-1:0] mult,
                                        input logic [CFG_W-1:0] div,
                                        input int unsigned      chan,
                                        input int unsigned      nch);
    return (div != '0) && (mult <= div) && (chan < nch);
  endfunction

endpackage

// File: rtl/frac_clken_chan.sv
// frac_clken_chan: one phase-accumulator channel producing registered
// one-cycle enable pulses at average rate MULT/DIV of the clock.
// Optional feature macro: FRAC_CLKEN_TOGGLE_EN adds the o_tgl square-wave output.
module frac_clken_chan
  import frac_clken_pkg::*;
#(
  parameter int unsigned W          = W_DEFAULT,
  parameter int unsigned RESET_MULT = 1,
  parameter int unsigned RESET_DIV  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_apply,
  input  logic [W-1:0] i_mult,
  input  logic [W-1:0] i_div,
  output logic         o_ce,
  output logic         o_wrap_c,
  output logic         o_mult_zero_c
`ifdef FRAC_CLKEN_TOGGLE_EN
  ,
  output logic         o_tgl
`endif
);

  logic [W-1:0] r_acc;
  logic [W-1:0] r_mult;
  logic [W-1:0] r_div;
  logic         r_ce;
  logic [W:0]   w_sum;
  logic         w_wrap;

  // One extra bit keeps acc+mult exact; acc<div and mult<=div bound it below 2*div.
  assign w_sum         = {1'b0, r_acc} + {1'b0, r_mult};
  assign w_wrap        = (r_mult != '0) && (w_sum >= {1'b0, r_div});
  assign o_wrap_c      = w_wrap;
  assign o_mult_zero_c = (r_mult == '0);
  assign o_ce          = r_ce;

  // Accumulator step; an apply reloads MULT/DIV and restarts the phase after the old wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_mult <= W'(RESET_MULT);
      r_div  <= W'(RESET_DIV);
      r_ce   <= 1'b0;
    end else begin
      r_ce <= w_wrap;
      if (i_apply) begin
        r_acc  <= '0;
        r_mult <= i_mult;
        r_div  <= i_div;
      end else if (r_mult != '0) begin
        r_acc <= w_wrap ? W'(w_sum - {1'b0, r_div}) : W'(w_sum);
      end
    end
  end

`ifdef FRAC_CLKEN_TOGGLE_EN
  logic r_tgl;

  assign o_tgl = r_tgl;

  // Half-rate square wave: flips on each enable pulse, restarts low on a config apply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tgl <= 1'b0;
    end else if (i_apply) begin
      r_tgl <= 1'b0;
    end else if (w_wrap) begin
      r_tgl <= ~r_tgl;
    end
  end
`endif

endmodule

// File: rtl/frac_clken_gen.sv
// frac_clken_gen: multi-channel fractional clock-enable generator with a
// single-slot runtime reconfiguration port; new MULT/DIV land at a channel wrap.
// Optional feature macro: FRAC_CLKEN_TOGGLE_EN adds clk_tgl[NCH-1:0].
module frac_clken_gen
  import frac_clken_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned W          = W_DEFAULT,
  parameter int unsigned RESET_MULT = 1,
  parameter int unsigned RESET_DIV  = 4
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [chan_w(NCH)-1:0] cfg_chan,
  input  logic [W-1:0]           cfg_mult,
  input  logic [W-1:0]           cfg_div,
  output logic                   cfg_err,
  output logic                   cfg_pending,
  output logic [NCH-1:0]         ce
`ifdef FRAC_CLKEN_TOGGLE_EN
  ,
  output logic [NCH-1:0]         clk_tgl
`endif
);

  cfg_t           r_slot;
  logic           r_pend;
  logic           r_ready;
  logic           r_err;

  cfg_t           w_req;
  logic           w_req_ok;
  logic           w_xfer;
  logic           w_hit;
  logic [NCH-1:0] w_wrap;
  logic [NCH-1:0] w_mult_zero;
  logic [NCH-1:0] w_apply;

  assign cfg_ready   = r_ready;
  assign cfg_err     = r_err;
  assign cfg_pending = r_pend;

  // Incoming request as a record, and its validity.
  assign w_req    = '{chan: CHAN_W'(cfg_chan), mult: CFG_W'(cfg_mult), div: CFG_W'(cfg_div)};
  assign w_req_ok = cfg_is_valid(CFG_W'(cfg_mult), CFG_W'(cfg_div), 32'(cfg_chan), NCH);
  assign w_xfer   = cfg_valid && r_ready;
  assign w_hit    = |w_apply;

  // Pending slot and handshake: apply frees the slot, a transfer fills it or flags an error.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_pend  <= 1'b0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_hit) begin
        r_pend  <= 1'b0;
        r_ready <= 1'b1;
      end else if (w_xfer) begin
        if (w_req_ok) begin
          r_slot  <= w_req;
          r_pend  <= 1'b1;
          r_ready <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Channel array; the pending config targets exactly one channel.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    // Apply at the target's wrap, or at once if the target is disabled.
    assign w_apply[g] = r_pend && (r_slot.chan == CHAN_W'(g)) &&
                        (w_wrap[g] || w_mult_zero[g]);

    frac_clken_chan #(
      .W          (W),
      .RESET_MULT (RESET_MULT),
      .RESET_DIV  (RESET_DIV)
    ) u_chan (
      .clk           (clkin),
      .rst_n         (rst_n),
      .i_apply       (w_apply[g]),
      .i_mult        (W'(r_slot.mult)),
      .i_div         (W'(r_slot.div)),
      .o_ce          (ce[g]),
      .o_wrap_c      (w_wrap[g]),
      .o_mult_zero_c (w_mult_zero[g])
`ifdef FRAC_CLKEN_TOGGLE_EN
      ,
      .o_tgl         (clk_tgl[g])
`endif
    );
  end

endmodule

// File: tb/tb_frac_clken_gen.sv
// tb_frac_clken_gen: directed bench for frac_clken_gen with a closed-form
// reference model (pulse count after k edges of a phase = floor(k*MULT/DIV)).
module tb_frac_clken_gen;

  localparam int NCH = 4;
  localparam int RM  = 1;
  localparam int RD  = 4;

  logic        clkin     = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_chan  = '0;
  logic [15:0] cfg_mult  = '0;
  logic [15:0] cfg_div   = '0;
  logic        cfg_ready;
  logic        cfg_err;
  logic        cfg_pending;
  logic [3:0]  ce;
`ifdef FRAC_CLKEN_TOGGLE_EN
  logic [3:0]  clk_tgl;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clkin = ~clkin;

  frac_clken_gen #(
    .NCH(NCH), .W(16), .RESET_MULT(RM), .RESET_DIV(RD)
  ) dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_mult    (cfg_mult),
    .cfg_div     (cfg_div),
    .cfg_err     (cfg_err),
    .cfg_pending (cfg_pending),
    .ce          (ce)
`ifdef FRAC_CLKEN_TOGGLE_EN
    ,
    .clk_tgl     (clk_tgl)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint     m_k    [NCH];
  longint     m_mult [NCH];
  longint     m_div  [NCH];
  logic [3:0] exp_ce;
  logic [3:0] exp_tgl;
  logic       exp_ready;
  logic       exp_err;
  logic       exp_pend;
  logic       m_rdy;
  int         p_chan;
  longint     p_mult;
  longint     p_div;
  logic       model_on = 1'b0;

  // Enable at the k-th edge of a phase: the floor(k*M/D) count steps up.
  function automatic logic pulse(input longint k, input longint m, input longint d);
    return (m != 0) && (((k * m) / d) != (((k - 1) * m) / d));
  endfunction

  always @(posedge clkin) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_k[i] = 0; m_mult[i] = RM; m_div[i] = RD;
      end
      exp_ce = '0; exp_tgl = '0; exp_ready = 1'b1; exp_err = 1'b0; exp_pend = 1'b0;
      p_chan = 0; p_mult = 0; p_div = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      m_rdy   = exp_ready;
      exp_err = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (m_mult[i] != 0) begin
          m_k[i]++;
          exp_ce[i] = pulse(m_k[i], m_mult[i], m_div[i]);
        end else begin
          exp_ce[i] = 1'b0;
        end
        exp_tgl[i] = exp_tgl[i] ^ exp_ce[i];
      end
      if (exp_pend && (exp_ce[p_chan] || m_mult[p_chan] == 0)) begin
        m_mult[p_chan] = p_mult; m_div[p_chan] = p_div; m_k[p_chan] = 0;
        exp_tgl[p_chan] = 1'b0;
        exp_pend = 1'b0; exp_ready = 1'b1;
      end else if (cfg_valid && m_rdy) begin
        if (cfg_div != 0 && cfg_mult <= cfg_div && int'(cfg_chan) < NCH) begin
          p_chan = int'(cfg_chan); p_mult = longint'(cfg_mult); p_div = longint'(cfg_div);
          exp_pend = 1'b1; exp_ready = 1'b0;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clkin) begin
    if (model_on) begin
      chk("ce", 64'(ce), 64'(exp_ce));
      chk("cfg_ready", 64'(cfg_ready), 64'(exp_ready));
      chk("cfg_err", 64'(cfg_err), 64'(exp_err));
      chk("cfg_pending", 64'(cfg_pending), 64'(exp_pend));
`ifdef FRAC_CLKEN_TOGGLE_EN
      chk("clk_tgl", 64'(clk_tgl), 64'(exp_tgl));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Present a request, wait (bounded) for ready, return just after the transfer edge.
  task automatic send_cfg(input int ch, input int m, input int d);
    int n;
    cfg_chan = 2'(ch); cfg_mult = 16'(m); cfg_div = 16'(d); cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 64) begin
      tick(); n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL cfg_ready_timeout actual=0 expected=1");
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  // Wait (bounded) for the pending config to apply; returns the edges taken.
  task automatic wait_apply(output int n);
    n = 0;
    while (cfg_pending && n < 64) begin
      tick(); n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL apply_timeout actual=%0d expected<64", n);
    end
  endtask

  initial begin
    int n;
    int cnt0;
    int cnt3;
    logic [15:0] pat1;
    logic [15:0] pat0;

    // 1: reset defaults, every channel fires at edges 4, 8, 12, ...
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ce", 64'(ce), 64'h0);
    chk("rst_ready", 64'(cfg_ready), 64'h1);
    chk("rst_pending", 64'(cfg_pending), 64'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      chk("t1_ce", 64'(ce), (e % 4 == 0) ? 64'hF : 64'h0);
    end

    // 2: ch1 -> 3/8, waits for ch1's wrap at edge 44, then spacing 3,3,2 from the restart
    send_cfg(1, 3, 8);
    chk("t2_ready_low", 64'(cfg_ready), 64'h0);
    chk("t2_pending", 64'(cfg_pending), 64'h1);
    wait_apply(n);
    chk("t2_apply_latency", 64'(n), 64'd3);
    chk("t2_apply_edge_ce", 64'(ce), 64'hF);
    chk("t2_ready_back", 64'(cfg_ready), 64'h1);
    pat1 = '0; pat0 = '0;
    for (int j = 0; j < 16; j++) begin
      tick();
      pat1[j] = ce[1];
      pat0[j] = ce[0];
    end
    chk("t2_ch1_pattern", 64'(pat1), 64'hA4A4);
    chk("t2_ch0_pattern", 64'(pat0), 64'h8888);

    // 3: invalid M>D on ch2: error pulse, nothing pending, ch2 keeps period 4
    send_cfg(2, 5, 3);
    chk("t3_err", 64'(cfg_err), 64'h1);
    chk("t3_pending", 64'(cfg_pending), 64'h0);
    chk("t3_ready", 64'(cfg_ready), 64'h1);
    tick();
    chk("t3_err_drop", 64'(cfg_err), 64'h0);
    cnt0 = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      cnt0 += int'(ce[2]);
    end
    chk("t3_ch2_count", 64'(cnt0), 64'd2);

    // 4: disable ch0, then re-enable at 1/2 which applies on the very next edge
    send_cfg(0, 0, 4);
    wait_apply(n);
    chk("t4_disable_latency", 64'(n), 64'd1);
    cnt0 = 0; cnt3 = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      cnt0 += int'(ce[0]);
      cnt3 += int'(ce[3]);
    end
    chk("t4_ch0_stuck", 64'(cnt0), 64'd0);
    chk("t4_ch3_count", 64'(cnt3), 64'd3);
    send_cfg(0, 1, 2);
    chk("t4_pending", 64'(cfg_pending), 64'h1);
    tick();
    chk("t4_applied", 64'(cfg_pending), 64'h0);
    chk("t4_ready", 64'(cfg_ready), 64'h1);
    pat0 = '0;
    for (int j = 0; j < 8; j++) begin
      tick();
      pat0[j] = ce[0];
    end
    chk("t4_ch0_pattern", 64'(pat0), 64'hAA);

    // 5: reset while a config is pending drops it and restores 1/4 phase
    send_cfg(3, 1, 16);
    chk("t5_pending", 64'(cfg_pending), 64'h1);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_pending", 64'(cfg_pending), 64'h0);
    chk("t5_rst_ready", 64'(cfg_ready), 64'h1);
    chk("t5_rst_ce", 64'(ce), 64'h0);
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("t5_ce", 64'(ce), (e % 4 == 0) ? 64'hF : 64'h0);
    end

`ifdef FRAC_CLKEN_TOGGLE_EN
    // 6: toggle output; two pulses since reset leave it low
    chk("t6_tgl_start", 64'(clk_tgl), 64'h0);
    send_cfg(0, 1, 1);
    wait_apply(n);
    chk("t6_tgl_cleared", 64'(clk_tgl[0]), 64'h0);
    pat0 = '0;
    for (int j = 0; j < 6; j++) begin
      tick();
      pat0[j] = clk_tgl[0];
    end
    chk("t6_tgl0_pattern", 64'(pat0), 64'h15);
    cnt0 = 0; cnt3 = 0;
    pat1[0] = clk_tgl[1];
    for (int j = 0; j < 16; j++) begin
      tick();
      cnt0 += int'(clk_tgl[1]);
      if (clk_tgl[1] != pat1[0]) cnt3++;
      pat1[0] = clk_tgl[1];
    end
    chk("t6_tgl1_high", 64'(cnt0), 64'd8);
    chk("t6_tgl1_edges", 64'(cnt3), 64'd4);
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
